ctrl_encoder: RTL and testbench

Inverse of the core's control decoder. Accepts a decoded control bundle plus register/immediate fields, recovers the 6-bit opcode, packs a 32-bit instruction word and streams it with a byte address to instruction-memory fill logic. Used by the program loader and by testbenches to build instruction images from control-level descriptions. Single-entry output register with valid/ready handshake, write-address counter, and illegal-bundle detection.

---
 rtl/ctrl_encoder.sv | 160 ++++++++++++++++
 tb/tb_ctrl_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_encoder.sv
// Control-bundle to instruction-word encoder: recovers the opcode from decoded
// control flags, packs the word and streams it with its byte address.
module ctrl_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  exe_cmd,
  input  logic        branch_en,
  input  logic        is_imm,
  input  logic        st_or_bne,
  input  logic        wb_en,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [1:0]  branch_command,
  input  logic [4:0]  dest,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        full,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] EXE_ADD = 4'd0, EXE_SUB = 4'd1, EXE_AND = 4'd2,
                         EXE_OR  = 4'd3, EXE_NOR = 4'd4, EXE_XOR = 4'd5,
                         EXE_SLA = 4'd6, EXE_SLL = 4'd7, EXE_SRA = 4'd8,
                         EXE_SRL = 4'd9, EXE_NO_OPERATION = 4'd15;

  localparam logic [1:0] COND_JUMP = 2'd0, COND_BEZ = 2'd1, COND_BNE = 2'd2;

  localparam logic [5:0] OP_ADD  = 6'd1,  OP_SUB  = 6'd3,  OP_AND  = 6'd5,
                         OP_OR   = 6'd6,  OP_NOR  = 6'd7,  OP_XOR  = 6'd8,
                         OP_SLA  = 6'd9,  OP_SLL  = 6'd10, OP_SRA  = 6'd11,
                         OP_SRL  = 6'd12, OP_ADDI = 6'd32, OP_SUBI = 6'd33,
                         OP_LD   = 6'd36, OP_ST   = 6'd37, OP_BEZ  = 6'd40,
                         OP_BNE  = 6'd41, OP_JMP  = 6'd42;

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {K_ILL, K_NOP, K_R, K_I} kind_e;

  kind_e       kind;
  logic [5:0]  opcode;
  logic [5:0]  flags;
  logic [31:0] word;
  logic        legal;
  logic        init_done;
  logic [CW-1:0] count;
  logic [CW:0] occupancy;
  logic        in_fire;
  logic        out_fire;

  assign flags = {branch_en, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en};

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    kind   = K_ILL;
    opcode = 6'd0;
    case (flags)
      6'b000000: if (exe_cmd == 4'd0 && branch_command == 2'd0) kind = K_NOP;
      6'b000100: begin
        kind = K_R;
        case (exe_cmd)
          EXE_ADD: opcode = OP_ADD;
          EXE_SUB: opcode = OP_SUB;
          EXE_AND: opcode = OP_AND;
          EXE_OR:  opcode = OP_OR;
          EXE_NOR: opcode = OP_NOR;
          EXE_XOR: opcode = OP_XOR;
          EXE_SLA: opcode = OP_SLA;
          EXE_SLL: opcode = OP_SLL;
          EXE_SRA: opcode = OP_SRA;
          EXE_SRL: opcode = OP_SRL;
          default: kind   = K_ILL;
        endcase
      end
      6'b010100: begin
        kind = K_I;
        case (exe_cmd)
          EXE_ADD: opcode = OP_ADDI;
          EXE_SUB: opcode = OP_SUBI;
          default: kind   = K_ILL;
        endcase
      end
      6'b011110: if (exe_cmd == EXE_ADD) begin kind = K_I; opcode = OP_LD; end
      6'b011001: if (exe_cmd == EXE_ADD) begin kind = K_I; opcode = OP_ST; end
      6'b110000: if (exe_cmd == EXE_NO_OPERATION) begin
        if (branch_command == COND_BEZ)  begin kind = K_I; opcode = OP_BEZ; end
        if (branch_command == COND_JUMP) begin kind = K_I; opcode = OP_JMP; end
      end
      6'b111000: if (exe_cmd == EXE_NO_OPERATION && branch_command == COND_BNE) begin
        kind = K_I; opcode = OP_BNE;
      end
      default: kind = K_ILL;
    endcase
  end

  always_comb begin
    word = 32'h0000_0000;
    case (kind)
      K_R:     word = {opcode, dest, src1, src2, 11'd0};
      K_I:     word = {opcode, dest, src1, imm};
      default: word = 32'h0000_0000;
    endcase
  end

  assign legal     = (kind != K_ILL);
  // Held word counts toward capacity so full rises as the last word is loaded.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, out_valid};
  assign full      = (occupancy == (CW+1)'(DEPTH));
  assign in_ready  = init_done & ~full & (~out_valid | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_addr  = BASE_ADDR + (32'(count) << 2);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_done <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= 32'h0000_0000;
      count     <= '0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      init_done <= 1'b1;
      if (clr) begin
        out_valid <= 1'b0;
        out_instr <= 32'h0000_0000;
        count     <= '0;
        err       <= 1'b0;
        err_cnt   <= 8'd0;
      end else begin
        if (out_fire && count != CW'(DEPTH)) count <= count + 1'b1;
        if (in_fire && legal) begin
          out_valid <= 1'b1;
          out_instr <= word;
        end else if (out_fire) begin
          out_valid <= 1'b0;
        end
        if (in_fire && !legal) begin
          err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_encoder.sv
// Directed self-checking bench for ctrl_encoder with DEPTH=4 and a non-zero
// base address; expected words are hand-packed from literal opcodes.
module tb_ctrl_encoder;

  localparam logic [31:0] B = 32'h0000_1000;

  // Flag order: {branch_en, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en}
  localparam logic [5:0] F_R = 6'b000100, F_I = 6'b010100, F_LD = 6'b011110,
                         F_ST = 6'b011001, F_BR = 6'b110000, F_BNE = 6'b111000,
                         F_BAD = 6'b000101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] exe_cmd = '0;
  logic branch_en = 0, is_imm = 0, st_or_bne = 0, wb_en = 0, mem_r_en = 0, mem_w_en = 0;
  logic [1:0] branch_command = '0;
  logic [4:0] dest = '0, src1 = '0, src2 = '0;
  logic [15:0] imm = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_instr, out_addr;
  logic full, err;
  logic [7:0] err_cnt;

  int total = 0;
  int passed = 0;
  int words = 0;

  ctrl_encoder #(.BASE_ADDR(B), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .branch_en(branch_en), .is_imm(is_imm), .st_or_bne(st_or_bne),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .branch_command(branch_command), .dest(dest), .src1(src1), .src2(src2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .full(full), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] e, input logic [5:0] f, input logic [1:0] bc,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [15:0] im);
    in_valid = 1'b1;
    exe_cmd  = e;
    {branch_en, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en} = f;
    branch_command = bc;
    dest = d; src1 = s1; src2 = s2; imm = im;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    exe_cmd = '0;
    {branch_en, is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en} = '0;
    branch_command = '0;
    dest = '0; src1 = '0; src2 = '0; imm = '0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, B);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    #2 rst = 1'b1;
    #1 check("in_ready_after_rst_release", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_one_cycle_later", 32'(in_ready), 32'd1);

    // ADD: one cycle latency
    drive(4'd0, F_R, 2'd0, 5'd3, 5'd1, 5'd2, 16'h0);
    @(negedge clk);
    idle();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_word", out_instr, {6'd1, 5'd3, 5'd1, 5'd2, 11'd0});
    check("add_addr", out_addr, B);
    @(negedge clk);
    check("add_drained", 32'(out_valid), 32'd0);
    check("add_addr_next", out_addr, B + 32'd4);

    // LD, ST, BNE back-to-back
    do_clr();
    check("clr_addr", out_addr, B);
    drive(4'd0, F_LD, 2'd0, 5'd4, 5'd2, 5'd0, 16'h0010);
    @(negedge clk);
    check("ld_word", out_instr, {6'd36, 5'd4, 5'd2, 16'h0010});
    check("ld_addr", out_addr, B);
    drive(4'd0, F_ST, 2'd0, 5'd5, 5'd6, 5'd0, 16'h0020);
    @(negedge clk);
    check("st_word", out_instr, {6'd37, 5'd5, 5'd6, 16'h0020});
    check("st_addr", out_addr, B + 32'd4);
    drive(4'd15, F_BNE, 2'd2, 5'd7, 5'd8, 5'd0, 16'hFFFC);
    @(negedge clk);
    idle();
    check("bne_word", out_instr, {6'd41, 5'd7, 5'd8, 16'hFFFC});
    check("bne_addr", out_addr, B + 32'd8);
    check("bne_valid", 32'(out_valid), 32'd1);

    // Illegal bundle between two legal R-type words
    do_clr();
    drive(4'd0, F_R, 2'd0, 5'd3, 5'd1, 5'd2, 16'h0);
    @(negedge clk);
    check("ill_first_word", out_instr, {6'd1, 5'd3, 5'd1, 5'd2, 11'd0});
    drive(4'd0, F_BAD, 2'd0, 5'd1, 5'd1, 5'd1, 16'h0);
    @(negedge clk);
    check("ill_no_word", 32'(out_valid), 32'd0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_err_cnt", 32'(err_cnt), 32'd1);
    check("ill_addr", out_addr, B + 32'd4);
    drive(4'd1, F_R, 2'd0, 5'd9, 5'd10, 5'd11, 16'h0);
    @(negedge clk);
    idle();
    check("ill_second_word", out_instr, {6'd3, 5'd9, 5'd10, 5'd11, 11'd0});
    check("ill_second_addr", out_addr, B + 32'd4);
    check("ill_err_sticky", 32'(err), 32'd1);
    do_clr();
    check("clr_err", 32'(err), 32'd0);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Output stall for five cycles
    out_ready = 1'b0;
    drive(4'd0, F_I, 2'd0, 5'd1, 5'd2, 5'd0, 16'h1234);
    @(negedge clk);
    drive(4'd1, F_I, 2'd0, 5'd3, 5'd4, 5'd0, 16'h8000);
    for (int i = 0; i < 5; i++) begin
      check("stall_word", out_instr, {6'd32, 5'd1, 5'd2, 16'h1234});
      check("stall_addr", out_addr, B);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    idle();
    check("release_word", out_instr, {6'd33, 5'd3, 5'd4, 16'h8000});
    check("release_addr", out_addr, B + 32'd4);
    @(negedge clk);
    check("release_drained_addr", out_addr, B + 32'd8);

    // Fill to DEPTH with six JMP bundles
    do_clr();
    words = 0;
    for (int i = 0; i < 6; i++) begin
      drive(4'd15, F_BR, 2'd0, 5'd0, 5'd0, 5'd0, 16'(i));
      @(negedge clk);
      if (out_valid) words++;
      if (words == 1 && out_valid) check("jmp_first_word", out_instr, {6'd42, 10'd0, 16'd0});
      if (words == 4 && out_valid) check("full_on_last_load", 32'(full), 32'd1);
    end
    idle();
    @(negedge clk);
    if (out_valid) words++;
    @(negedge clk);
    check("fill_word_count", 32'(words), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_addr", out_addr, B + 32'd16);

    // clr releases full; NOP emitted at base
    do_clr();
    check("clr_full", 32'(full), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    drive(4'd0, 6'b000000, 2'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF);
    @(negedge clk);
    idle();
    check("nop_valid", 32'(out_valid), 32'd1);
    check("nop_word", out_instr, 32'h0);
    check("nop_addr", out_addr, B);

    // clr wins over a simultaneous handshake
    @(negedge clk);
    drive(4'd2, F_R, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    idle();
    check("clr_wins_valid", 32'(out_valid), 32'd0);
    check("clr_wins_addr", out_addr, B);

    // Async reset mid-stall
    drive(4'd0, F_BAD, 2'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'd9, F_R, 2'd0, 5'd2, 5'd3, 5'd4, 16'h0);
    @(negedge clk);
    idle();
    check("pre_rst_word", out_instr, {6'd12, 5'd2, 5'd3, 5'd4, 11'd0});
    check("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_instr", out_instr, 32'h0);
    check("async_out_addr", out_addr, B);
    check("async_err", 32'(err), 32'd0);
    check("async_err_cnt", 32'(err_cnt), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
